// File: rtl/ydm_responder.sv
// Load/store responder for a simple CPU: one request at a time, WAIT wait states, word memory.
// Define YDM_ALIGN_CHECK_EN to reject misaligned requests with resp_err.
module ydm_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    // state     | meaning
    // ST_IDLE   | ready for a request
    // ST_WAIT   | counting down wait states
    // ST_RESP   | response held until resp_ready
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam int AW = DEPTH_LOG2 + 2;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            capture;
    logic            enter_resp;

    logic            acc_write;
    logic [AW-1:0]   acc_addr;
    logic [31:0]     acc_wdata;
    logic            acc_err;
    logic [31:0]     mem_rdata;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    // With WAIT=0 the access happens on the accepting edge, so use the live request.
    assign acc_write = (state_q == ST_IDLE) ? req_write : write_q;
    assign acc_addr  = (state_q == ST_IDLE) ? req_addr[AW-1:0] : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign mem_rdata = mem[acc_addr[AW-1:2]];

    logic unused_ok;
    assign unused_ok = ^{req_addr[31:AW], acc_addr[1:0]};

`ifdef YDM_ALIGN_CHECK_EN
    logic err_q;

    assign acc_err  = (acc_addr[1:0] != 2'b00);
    assign resp_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= acc_err;
        end
    end
`else
    assign acc_err  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (WAIT == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                write_q <= req_write;
                addr_q  <= req_addr[AW-1:0];
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= (acc_write || acc_err) ? 32'd0 : mem_rdata;
            end
        end
    end

    // Memory is deliberately not reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_write && !acc_err) begin
            mem[acc_addr[AW-1:2]] <= acc_wdata;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign resp_rdata = rdata_q;

endmodule
